// File: rtl/instr_sequencer.sv
// Program loader/replayer: packs UART bytes into 32-bit instructions, buffers them,
// and replays the buffer into the core with an execute cycle then a write-back cycle each.
package yongatek_pkg;
  typedef logic [31:0] yongatek_instruction_t;
endpackage

module instr_sequencer
  import yongatek_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_data,
  input  logic                       start,
  input  logic                       clr,
  output yongatek_instruction_t      instruction,
  output logic                       write_ctrl,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       rx_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]            state;
  logic [1:0]            byte_cnt;
  logic [23:0]           asm_q;
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         rd_next;
  logic                  wr_en;
  logic                  asm_en;
  logic                  last_entry;
  yongatek_instruction_t mem [DEPTH];

  assign asm_en     = !clr && (state == S_IDLE) && rx_valid && (byte_cnt != 2'd3);
  assign wr_en      = !clr && (state == S_IDLE) && rx_valid && (byte_cnt == 2'd3) && (count != FULL);
  assign rd_next    = rd_ptr + AW'(1);
  assign last_entry = ({1'b0, rd_ptr} == (count - CW'(1)));

  // Storage is data only: no reset, contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[count[AW-1:0]] <= {asm_q, rx_data};
    if (asm_en) asm_q <= {asm_q[15:0], rx_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      byte_cnt    <= 2'd0;
      rd_ptr      <= '0;
      count       <= '0;
      rx_drop     <= 1'b0;
      instruction <= '0;
      write_ctrl  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else if (clr) begin
      state       <= S_IDLE;
      byte_cnt    <= 2'd0;
      rd_ptr      <= '0;
      count       <= '0;
      rx_drop     <= 1'b0;
      instruction <= '0;
      write_ctrl  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rx_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (count == FULL) rx_drop <= 1'b1;
              else               count   <= count + CW'(1);
            end
          end
          if (start && (count != '0)) begin
            state       <= S_EXEC;
            rd_ptr      <= '0;
            instruction <= mem[AW'(0)];
            write_ctrl  <= 1'b0;
            busy        <= 1'b1;
          end
        end
        S_EXEC: begin
          write_ctrl <= 1'b1;
          state      <= S_WB;
        end
        S_WB: begin
          write_ctrl <= 1'b0;
          if (last_entry) begin
            state       <= S_DONE;
            instruction <= '0;
            busy        <= 1'b0;
            done        <= 1'b1;
          end else begin
            state       <= S_EXEC;
            rd_ptr      <= rd_next;
            instruction <= mem[rd_next];
          end
        end
        default: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
      // Bytes arriving mid-replay are lost; the byte counter is left alone.
      if (rx_valid && (state != S_IDLE)) rx_drop <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a vector table for load/replay/clear,
// then hand-written sequences for the 3-word replay, full buffer, abort and async reset.
module tb_instr_sequencer;

  logic        clk;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        start;
  logic        clr;
  logic [31:0] instruction;
  logic        write_ctrl;
  logic        busy;
  logic        done;
  logic [4:0]  count;
  logic        rx_drop;

  int checks = 0;
  int errors = 0;

  instr_sequencer #(.DEPTH(16)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .start(start), .clr(clr), .instruction(instruction),
    .write_ctrl(write_ctrl), .busy(busy), .done(done),
    .count(count), .rx_drop(rx_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        st;
    logic        cl;
    logic [31:0] ei;
    logic        ew;
    logic        eb;
    logic        ed;
    logic [4:0]  ec;
    logic        edr;
  } vec_t;

  vec_t tbl [$];

  // Inputs change at the falling edge; outputs are sampled at the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] ei, input logic ew,
                     input logic eb, input logic ed, input logic [4:0] ec, input logic edr);
    checks++;
    if (instruction !== ei || write_ctrl !== ew || busy !== eb || done !== ed ||
        count !== ec || rx_drop !== edr) begin
      errors++;
      $display("FAIL %s: got instr=%h wc=%b busy=%b done=%b count=%0d drop=%b, expected instr=%h wc=%b busy=%b done=%b count=%0d drop=%b",
               name, instruction, write_ctrl, busy, done, count, rx_drop, ei, ew, eb, ed, ec, edr);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) begin
      rx_valid = 1'b1;
      rx_data  = w[b*8 +: 8];
      cyc();
    end
    rx_valid = 1'b0;
  endtask

  logic [31:0] exp_i [9];
  logic        exp_w [9];
  logic        exp_b [9];
  logic        exp_d [9];

  initial begin
    rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; start = 1'b0; clr = 1'b0;

    tbl.push_back('{1'b1, 8'h12, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd0, 1'b0});
    tbl.push_back('{1'b1, 8'h34, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd0, 1'b0});
    tbl.push_back('{1'b1, 8'h56, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd0, 1'b0});
    tbl.push_back('{1'b1, 8'h78, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd1, 1'b0});
    tbl.push_back('{1'b1, 8'hAA, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd1, 1'b0});
    tbl.push_back('{1'b1, 8'hBB, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd1, 1'b0});
    tbl.push_back('{1'b1, 8'hCC, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd1, 1'b0});
    tbl.push_back('{1'b1, 8'hDD, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd2, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 32'h12345678, 1'b0, 1'b1, 1'b0, 5'd2, 1'b0});
    tbl.push_back('{1'b1, 8'hEE, 1'b0, 1'b0, 32'h12345678, 1'b1, 1'b1, 1'b0, 5'd2, 1'b1});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 32'hAABBCCDD, 1'b0, 1'b1, 1'b0, 5'd2, 1'b1});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 32'hAABBCCDD, 1'b1, 1'b1, 1'b0, 5'd2, 1'b1});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 5'd2, 1'b1});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd2, 1'b1});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 32'h12345678, 1'b0, 1'b1, 1'b0, 5'd2, 1'b1});
    tbl.push_back('{1'b1, 8'h55, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 5'd0, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd0, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd0, 1'b0});

    cyc();
    cyc();
    chk("reset_state", 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    rst = 1'b1;
    cyc();

    for (int i = 0; i < tbl.size(); i++) begin
      rx_valid = tbl[i].v; rx_data = tbl[i].d; start = tbl[i].st; clr = tbl[i].cl;
      cyc();
      chk($sformatf("vec%0d", i), tbl[i].ei, tbl[i].ew, tbl[i].eb, tbl[i].ed, tbl[i].ec, tbl[i].edr);
    end
    rx_valid = 1'b0; start = 1'b0; clr = 1'b0;

    // Three-word program with start held high: replay, done, idle, replay again.
    send_word(32'h11223344);
    send_word(32'h55667788);
    send_word(32'h99AABBCC);
    chk("load3_count", 32'h0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b0);
    exp_i = '{32'h11223344, 32'h11223344, 32'h55667788, 32'h55667788,
              32'h99AABBCC, 32'h99AABBCC, 32'h0, 32'h0, 32'h11223344};
    exp_w = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_b = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_d = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    start = 1'b1;
    for (int k = 0; k < 9; k++) begin
      cyc();
      chk($sformatf("replay3_t%0d", k + 1), exp_i[k], exp_w[k], exp_b[k], exp_d[k], 5'd3, 1'b0);
    end
    start = 1'b0;
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("clr_after_replay3", 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);

    // Seventeen words into a 16-entry buffer: the last one is discarded.
    for (int i = 0; i < 17; i++) begin
      send_word(32'hC0DE0000 | i);
      if (i == 15) chk("full_count16", 32'h0, 1'b0, 1'b0, 1'b0, 5'd16, 1'b0);
    end
    chk("overflow_drop", 32'h0, 1'b0, 1'b0, 1'b0, 5'd16, 1'b1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int e = 0; e < 16; e++) begin
      chk($sformatf("full_exec%0d", e), 32'hC0DE0000 | e, 1'b0, 1'b1, 1'b0, 5'd16, 1'b1);
      cyc();
      chk($sformatf("full_wb%0d", e), 32'hC0DE0000 | e, 1'b1, 1'b1, 1'b0, 5'd16, 1'b1);
      cyc();
    end
    chk("full_done", 32'h0, 1'b0, 1'b0, 1'b1, 5'd16, 1'b1);
    cyc();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("full_clr", 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);

    // Byte dropped mid-replay, then abort with clr in entry 1's write-back cycle.
    send_word(32'hA0A0A0A0);
    send_word(32'hB1B1B1B1);
    send_word(32'hC2C2C2C2);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("abort_exec0", 32'hA0A0A0A0, 1'b0, 1'b1, 1'b0, 5'd3, 1'b0);
    rx_valid = 1'b1; rx_data = 8'hAA;
    cyc();
    rx_valid = 1'b0;
    chk("abort_wb0_drop", 32'hA0A0A0A0, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1);
    cyc();
    chk("abort_exec1", 32'hB1B1B1B1, 1'b0, 1'b1, 1'b0, 5'd3, 1'b1);
    cyc();
    chk("abort_wb1", 32'hB1B1B1B1, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("abort_cleared", 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("abort_no_done%0d", k), 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    end

    // Asynchronous reset between clock edges during an execute cycle.
    send_word(32'hDEADBEEF);
    send_word(32'h01020304);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("rst_pre_exec", 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 5'd2, 1'b0);
    #1 rst = 1'b0;
    #1;
    chk("rst_async", 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    #1 rst = 1'b1;
    @(negedge clk);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("rst_start_ignored", 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    cyc();
    chk("rst_still_idle", 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Controller between the UART receive path and the processor core. It assembles 4-byte words arriving from the UART receiver into 32-bit `yongatek_instruction_t` instructions and stores them in an internal program buffer. On `start` it replays the buffer into the processor, one instruction at a time, and drives `write_ctrl` so that each instruction gets one execute cycle followed by one register write-back cycle.

## Interface
- `DEPTH`, default 16: number of program buffer entries; power of two, ≥2.
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `rx_valid`, in, 1: one-cycle strobe; `rx_data` holds a received byte.
- `rx_data`, in, 8: received byte.
- `start`, in, 1: level sampled each cycle; begins program replay.
- `clr`, in, 1: synchronous clear of the program buffer and error state; aborts replay.
- `instruction`, out, 32 (`yongatek_instruction_t`): instruction presented to the processor.
- `write_ctrl`, out, 1: register-file write enable to the processor.
- `busy`, out, 1: high while replaying.
- `done`, out, 1: one-cycle pulse after the last instruction's write-back cycle.
- `count`, out, $clog2(DEPTH)+1: number of complete instructions stored.
- `rx_drop`, out, 1: sticky flag, set when a received byte or word is discarded.

## Operation
- Reset values: `instruction`=0, `write_ctrl`=0, `busy`=0, `done`=0, `count`=0, `rx_drop`=0; byte counter, write pointer and read pointer all 0; state IDLE. Buffer contents are don't-care after reset.
- States:
  - IDLE: load bytes, wait for `start`.
  - EXEC: current instruction driven, `write_ctrl`=0.
  - WB: same instruction held, `write_ctrl`=1.
  - DONE: one cycle, `done`=1.
- Byte assembly (IDLE only):
  - Byte order is MSB first. Byte 0 goes to [31:24], byte 1 to [23:16], byte 2 to [15:8], byte 3 to [7:0].
  - A 2-bit byte counter wraps from 3 to 0.
  - On the 4th byte, the word is written to `buf[count]` and `count` increments.
- Full buffer:
  - When `count`==DEPTH, a completed 4th byte discards the word and sets `rx_drop`.
  - `count` saturates at DEPTH.
  - Bytes 0–2 are still accepted into the assembly register.
- Any `rx_valid` outside IDLE discards the byte, sets `rx_drop`, and leaves the byte counter unchanged.
- `start` in IDLE:
  - With `count`>0: go to EXEC with read pointer 0.
  - With `count`=0: ignored; stay in IDLE.
  - Outside IDLE: ignored.
- Replay sequence: EXEC → WB → then EXEC with the next entry, or DONE after entry `count`−1. DONE always returns to IDLE.
- The buffer is preserved after replay; a later `start` replays the same program.
- Outside EXEC/WB, `instruction`=0 and `write_ctrl`=0.
- `clr` has priority over everything except `rst`:
  - Next cycle: state IDLE, `count`=0, byte counter 0, `rx_drop`=0, outputs at reset values.
  - A `rx_valid` in the same cycle as `clr` is discarded without setting `rx_drop`.
- `rst` asserted mid-replay: immediate return to reset values; no partial write-back is guaranteed.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- 4th byte strobed at cycle t: `count` updates at t+1, and the word is readable from t+1.
- `start` sampled at cycle t in IDLE:
  - t+1: `busy`=1, `instruction`=`buf[0]`, `write_ctrl`=0.
  - t+2: `write_ctrl`=1.
  - Entry k is in EXEC at t+1+2k.
- N-instruction program:
  - `busy` high for cycles t+1 through t+2N.
  - `done`=1 and `busy`=0 at t+2N+1.
  - IDLE at t+2N+2, where a new `start` is accepted.
- `start` held high continuously: the program replays again beginning at t+2N+3.

## Test plan
- Reset, then send bytes 0x12,0x34,0x56,0x78 → `count`=1 one cycle after the 4th byte; `buf[0]`=0x12345678; `rx_drop`=0.
- Load 3 words A,B,C and pulse `start` at cycle t → `instruction`=A,A,B,B,C,C over t+1..t+6; `write_ctrl`=0,1,0,1,0,1; `done` pulses at t+7; `busy`=0 from t+7.
- With DEPTH=16, load 17 words → `count`=16, `rx_drop`=1, `buf[15]` holds word 16. Then `clr` → `count`=0 and `rx_drop`=0 next cycle.
- Pulse `start` with `count`=0 → stays IDLE; `busy`, `write_ctrl` and `done` stay 0.
- During replay, strobe `rx_valid` with 0xAA → `rx_drop`=1 and the replay sequence is unchanged. Then assert `clr` at entry 1's WB cycle → next cycle `instruction`=0, `write_ctrl`=0, `busy`=0, no `done` pulse.
- Assert `rst` low asynchronously mid-EXEC (between clock edges) → all outputs are 0 before the next rising edge; after release, `start` with `count`=0 is ignored.
